// File: rtl/sd_sector_mem_writer_pkg.sv
// Shared types and constants for the SD sector to on-chip memory writer.
package sd_mem_writer_pkg;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int SECTOR_BYTES   = 512;
endpackage

// File: rtl/sd_sector_mem_writer_if.sv
// Avalon-MM write-only bus between the sector writer and the on-chip memory.
interface sd_sector_mem_writer_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
    input  avm_waitrequest
  );
  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sd_sector_mem_writer_byte_packer.sv
// Packs stream bytes little-endian into a 32-bit word with per-lane byte enables.
module sd_byte_packer
  import sd_mem_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [3:0]  byteenable,
  output logic        word_full
);
  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [3:0]        be_q, be_d;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    be_d   = be_q;
    if (clear) begin
      lane_d = '0;
      word_d = '0;
      be_d   = '0;
    end else if (load) begin
      word_d[8*lane_q +: 8] = byte_in;
      be_d[lane_q]          = 1'b1;
      lane_d                = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      be_q   <= be_d;
    end
  end

  assign word       = word_q;
  assign byteenable = be_q;
  // Asserted when the next loaded byte completes the word.
  assign word_full  = (lane_q == LANE_W'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/sd_sector_mem_writer.sv
// Streams SD receiver bytes into on-chip RAM as packed 32-bit Avalon-MM writes.
//   state | meaning
//   IDLE  | waiting for start
//   FILL  | accepting stream bytes into the word register
//   WRITE | Avalon write in flight, held while waitrequest
//   DONE  | one-cycle completion pulse
module sd_sector_mem_writer
  import sd_mem_writer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  byte_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic [7:0]        st_data,
  input  logic              st_valid,
  output logic              st_ready,
  sd_sector_mem_writer_if.master avm
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              abort_pend_q, abort_pend_d;

  logic        pack_clear, pack_load, pack_full;
  logic [31:0] pack_word;
  logic [3:0]  pack_be;

  sd_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pack_clear),
    .load       (pack_load),
    .byte_in    (st_data),
    .word       (pack_word),
    .byteenable (pack_be),
    .word_full  (pack_full)
  );

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    remaining_d        = remaining_q;
    abort_pend_d       = abort_pend_q;
    pack_clear         = 1'b0;
    pack_load          = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    st_ready           = 1'b0;
    avm.avm_write      = 1'b0;
    avm.avm_chipselect = 1'b0;
    avm.avm_address    = '0;
    avm.avm_byteenable = '0;
    avm.avm_writedata  = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          remaining_d  = byte_count;
          abort_pend_d = 1'b0;
          pack_clear   = 1'b1;
          state_d      = (byte_count == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        busy     = 1'b1;
        st_ready = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (st_valid) begin
          pack_load   = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (pack_full || remaining_q == LEN_W'(1)) state_d = WRITE;
        end
      end
      WRITE: begin
        busy               = 1'b1;
        avm.avm_write      = 1'b1;
        avm.avm_chipselect = 1'b1;
        avm.avm_address    = addr_q;
        avm.avm_byteenable = pack_be;
        avm.avm_writedata  = pack_word;
        if (!avm.avm_waitrequest) begin
          addr_d       = addr_q + 1'b1;
          pack_clear   = 1'b1;
          abort_pend_d = 1'b0;
          // An abort seen during the stall still ends the transfer once the write lands.
          if (abort || abort_pend_q)   state_d = IDLE;
          else if (remaining_q == '0)  state_d = DONE;
          else                         state_d = FILL;
        end else if (abort) begin
          abort_pend_d = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      abort_pend_q <= abort_pend_d;
    end
  end
endmodule
